mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max busy cycles before bus error (only used under BUS_TIMEOUT_EN).
REQ-003 SHALL have ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have fetch port: iReq in 1 fetch request; iAddr in XLEN address; iRdata out XLEN read data; iAck out 1 completion pulse.
REQ-005 SHALL have data port: dReq in 1; dWe in 1 write enable; dMask in 4 byte mask; dAddr in XLEN; dWdata in XLEN; dRdata out XLEN; dAck out 1.
REQ-006 SHALL have memory port: mReq out 1; mWe out 1; mMask out 4; mAddr out XLEN; mWdata out XLEN; mRdata in XLEN; mAck in 1 completion (may be same cycle as mReq).
REQ-007 SHALL have busErr out 1, error pulse qualifying the accompanying iAck/dAck.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-009 IDLE: mReq=0; iAck=dAck=0; on any pending request, SHALL move at next edge to BUSY_I or BUSY_D.
REQ-010 Tie (iReq and dReq both high in IDLE): SHALL grant the port not granted last; lastGrant register updated on every grant.
REQ-011 Single request in IDLE: SHALL grant that port regardless of lastGrant.
REQ-012 BUSY_x: mReq=1; mWe, mMask, mAddr, mWdata SHALL be driven from granted port (fetch grant: mWe=0, mMask=4'b1111, mWdata=0).
REQ-013 BUSY_x with mAck=1: SHALL pulse granted ack in same cycle (combinational from mAck), route mRdata to granted rdata, return to IDLE at next edge.
REQ-014 Non-granted ack SHALL be 0; non-granted rdata SHALL be 0.
REQ-015 Minimum transaction: one IDLE cycle plus one BUSY cycle; back-to-back requests SHALL therefore see one idle cycle between mReq pulses.
REQ-016 Requesters hold req and qualifiers stable until ack; dropping req mid-transaction SHALL NOT abort it (ack still pulses).
REQ-017 mAck while in IDLE SHALL be ignored.

Reset
REQ-018 On reset: state=IDLE, lastGrant=data (fetch wins first tie), timeout counter=0, all outputs 0 in following cycle.
REQ-019 Reset during BUSY SHALL abandon the transaction: mReq=0 and no ack in the cycle after reset.

Configuration
REQ-020 Macro BUS_TIMEOUT_EN defined: 8-bit-plus counter (width $clog2(TIMEOUT_CYCLES+1)) clears on grant, increments each BUSY cycle without mAck; when it equals TIMEOUT_CYCLES, SHALL pulse granted ack with busErr=1, rdata=0, mReq=0 at next edge, return to IDLE.
REQ-021 mAck in the same cycle as timeout SHALL win (normal completion, busErr=0).
REQ-022 Macro undefined: no counter, busErr tied 0, BUSY waits indefinitely.

Structure
REQ-023 State encoding (IDLE/BUSY_I/BUSY_D) and grant encoding SHALL live in the shared constants header alongside XLEN.
REQ-024 SHALL be a single module; no sub-modules; the cpu fetch/data ports connect to it with a stall derived from ack.

Verification
REQ-025 Fetch only, mAck same cycle, iAddr=0x100, mRdata=0x00000013 -> mReq one cycle, iAck pulse, iRdata=0x00000013, dAck=0.
REQ-026 Both request after reset, dAddr=0x200 dWe=1 dMask=4'b0011 dWdata=0xBEEF -> fetch served first, then data with mWe=1 mMask=0011 mWdata=0xBEEF, one IDLE cycle between.
REQ-027 Both held continuously for 6 transactions -> grants alternate I,D,I,D,I,D.
REQ-028 Memory with 3 wait states -> mReq high 4 cycles, ack on 4th, request signals stable throughout.
REQ-029 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, mAck never -> dAck and busErr pulse together after 4 BUSY cycles, dRdata=0, FSM IDLE next cycle; without macro mReq stays high.
REQ-030 reset asserted during BUSY_D -> mReq=0, no dAck, next tie grants fetch.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: the default bus width, the
// FSM state encoding, the grant encoding, and the tie-break helper.
package mem_arbiter_pkg;

    // Default data/address width of the fetch, data and memory buses.
    localparam int DEFAULT_XLEN = 32;

    // FSM state encoding. The value 2'b11 is never entered on purpose and
    // falls back to IDLE.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    // Grant encoding, also the encoding of the lastGrant register.
    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    // Decide which port wins in IDLE. Returns GRANT_DATA or GRANT_FETCH.
    // With both ports requesting, the port that did not win last time is
    // chosen. A lone requester always wins.
    function automatic logic pickGrant(input logic iReqIn,
                                       input logic dReqIn,
                                       input logic lastGrantIn);
        if (iReqIn && dReqIn) begin
            return (lastGrantIn == GRANT_FETCH) ? GRANT_DATA : GRANT_FETCH;
        end
        return dReqIn ? GRANT_DATA : GRANT_FETCH;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a CPU fetch port and a CPU data port share one
// memory port. One transaction at a time; ties alternate between ports.
//
// Handshake: a requester raises req with stable qualifiers and holds them
// until its ack pulses for one cycle. The memory side sees mReq held high
// with stable qualifiers until it answers with a one-cycle mAck, which may
// arrive in the very first mReq cycle. The requester ack is combinational
// from mAck, so the CPU stall can be derived directly from it.
//
// Optional feature macro: BUS_TIMEOUT_EN. When defined, a transaction that
// sees no mAck for TIMEOUT_CYCLES busy cycles is completed with busErr=1.
// When undefined, busErr is tied low and BUSY waits indefinitely.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN           = DEFAULT_XLEN,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,

    // Fetch port
    input  logic            iReq,
    input  logic [XLEN-1:0] iAddr,
    output logic [XLEN-1:0] iRdata,
    output logic            iAck,

    // Data port
    input  logic            dReq,
    input  logic            dWe,
    input  logic [3:0]      dMask,
    input  logic [XLEN-1:0] dAddr,
    input  logic [XLEN-1:0] dWdata,
    output logic [XLEN-1:0] dRdata,
    output logic            dAck,

    // Memory port
    output logic            mReq,
    output logic            mWe,
    output logic [3:0]      mMask,
    output logic [XLEN-1:0] mAddr,
    output logic [XLEN-1:0] mWdata,
    input  logic [XLEN-1:0] mRdata,
    input  logic            mAck,

    // Error qualifier for iAck/dAck
    output logic            busErr,

    // Current FSM state, for observation only
    output logic [1:0]      dbgState
);

    // A timeout of zero cycles would complete every transaction with an
    // error before memory had a chance to answer.
    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0] state;
    logic [1:0] stateNext;
    logic       lastGrant;
    logic       grantSel;
    logic       anyReq;
    logic       busyI;
    logic       busyD;
    logic       busy;
    logic       timeoutHit;
    logic       done;

    assign anyReq   = iReq || dReq;
    assign grantSel = pickGrant(iReq, dReq, lastGrant);
    assign busyI    = (state == ST_BUSY_I);
    assign busyD    = (state == ST_BUSY_D);
    assign busy     = busyI || busyD;
    assign dbgState = state;

    // A transaction ends on memory acknowledge or, when enabled, on timeout.
    // mAck in the timeout cycle still counts as a normal completion.
    assign done = busy && (mAck || timeoutHit);

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] busyCount;

    // Count busy cycles that passed without an answer; cleared while idle,
    // so every grant starts from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            busyCount <= '0;
        end else if (!busy) begin
            busyCount <= '0;
        end else if (!mAck && !timeoutHit) begin
            busyCount <= busyCount + 1'b1;
        end
    end

    assign timeoutHit = busy && (busyCount == TO_W'(TIMEOUT_CYCLES));
`else
    assign timeoutHit = 1'b0;
`endif

    // Next-state logic: IDLE grants any pending request, BUSY waits for done.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (anyReq) begin
                    stateNext = (grantSel == GRANT_DATA) ? ST_BUSY_D : ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (done) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // State and grant-history registers. lastGrant resets to data so the
    // first tie after reset goes to fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            lastGrant <= GRANT_DATA;
        end else begin
            state <= stateNext;
            if ((state == ST_IDLE) && anyReq) begin
                lastGrant <= grantSel;
            end
        end
    end

    // Memory-side mux: qualifiers come live from the granted port, which
    // holds them stable for the whole transaction. Everything is zero in IDLE.
    always_comb begin
        mReq   = busy;
        mWe    = 1'b0;
        mMask  = 4'b0000;
        mAddr  = '0;
        mWdata = '0;
        if (busyD) begin
            mWe    = dWe;
            mMask  = dMask;
            mAddr  = dAddr;
            mWdata = dWdata;
        end else if (busyI) begin
            mMask  = 4'b1111;
            mAddr  = iAddr;
        end
    end

    // Requester-side return path: only the granted port sees ack and data.
    // Read data is forwarded only on a real memory answer, so a timed-out
    // transaction returns zero.
    always_comb begin
        iAck   = busyI && done;
        dAck   = busyD && done;
        busErr = busy && timeoutHit && !mAck;
        iRdata = '0;
        dRdata = '0;
        if (busyI && mAck) begin
            iRdata = mRdata;
        end
        if (busyD && mAck) begin
            dRdata = mRdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// each cycle compared against a transaction-level model of the arbiter.
// Honors BUS_TIMEOUT_EN when the DUT is built with it.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int XLEN = 32;
    localparam int TO   = 4;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic            iReq = 1'b0, iAck;
    logic [XLEN-1:0] iAddr = '0, iRdata;
    logic            dReq = 1'b0, dWe = 1'b0, dAck;
    logic [3:0]      dMask = '0;
    logic [XLEN-1:0] dAddr = '0, dWdata = '0, dRdata;
    logic            mReq, mWe, mAck = 1'b0;
    logic [3:0]      mMask;
    logic [XLEN-1:0] mAddr, mWdata, mRdata = '0;
    logic            busErr;
    logic [1:0]      dbgState;

    mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .iReq(iReq), .iAddr(iAddr), .iRdata(iRdata), .iAck(iAck),
        .dReq(dReq), .dWe(dWe), .dMask(dMask), .dAddr(dAddr), .dWdata(dWdata),
        .dRdata(dRdata), .dAck(dAck),
        .mReq(mReq), .mWe(mWe), .mMask(mMask), .mAddr(mAddr), .mWdata(mWdata),
        .mRdata(mRdata), .mAck(mAck),
        .busErr(busErr), .dbgState(dbgState)
    );

    // ---------------- counters / scoreboard ----------------
    int nVectors = 0;
    int nMiscompares = 0;
    logic [0:0] exp_q[$];    // expected order of completions (1 = data)
    logic [0:0] grantLog[$]; // observed completions (1 = data)

    // Reference model: a transaction in flight or not, who owns it, who won
    // last, and how many busy cycles passed without an answer.
    bit mdlBusy = 0, mdlOnData = 0, mdlLastData = 1;
    int mdlCnt = 0;

    // Requester and memory stimulus state
    bit iPend = 0, dPend = 0, iDrop = 0, dDrop = 0, iDone = 0, dDone = 0;
    bit refillI = 0, refillD = 0;
    bit memNever = 0, memFixedEn = 0;
    logic [XLEN-1:0] memFixed = '0;
    int memWaits = 0, memSeen = 0;
    int reqCyc = 0, stepCount = 0, errCount = 0;
    logic [XLEN-1:0] lastIRdata = '0, capWdata = '0;
    logic capWe = 1'b0;
    logic [3:0] capMask = '0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic newFetch(input logic [XLEN-1:0] a);
        iPend = 1; iDrop = 0; iAddr = a;
    endtask

    task automatic newData(input logic [XLEN-1:0] a, input logic we,
                           input logic [3:0] mask, input logic [XLEN-1:0] wd);
        dPend = 1; dDrop = 0; dAddr = a; dWe = we; dMask = mask; dWdata = wd;
    endtask

    // Retire completed requests; optionally start a new one right away.
    task automatic serviceDone();
        if (iDone) begin
            iPend = 0; iDrop = 0; iDone = 0;
            if (refillI) newFetch($urandom);
        end
        if (dDone) begin
            dPend = 0; dDrop = 0; dDone = 0;
            if (refillD) newData($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        end
    endtask

    task automatic driveReq();
        iReq = iPend && !iDrop;
        dReq = dPend && !dDrop;
    endtask

    // One clock cycle. Entered just after a rising edge with requester inputs
    // already applied; returns just after the next rising edge.
    task automatic step(input bit chk);
        bit toNow, eAck, pickD;
        logic [0:0] eq;
        // memory model reacts to the bus it sees
        if (mReq) begin
            mAck   = !memNever && (memSeen >= memWaits);
            mRdata = memFixedEn ? memFixed : $urandom;
        end else begin
            mAck   = ($urandom_range(0, 3) == 0);
            mRdata = $urandom;
        end
        #1;
        toNow = TO_EN && mdlBusy && (mdlCnt == TO);
        eAck  = mdlBusy && (mAck || toNow);
        if (chk && !reset) begin
            checkVal("mReq",   mReq, mdlBusy);
            checkVal("mWe",    mWe, mdlBusy && mdlOnData && dWe);
            checkVal("mMask",  mMask, !mdlBusy ? 4'h0 : (mdlOnData ? dMask : 4'hF));
            checkVal("mAddr",  mAddr, !mdlBusy ? 32'h0 : (mdlOnData ? dAddr : iAddr));
            checkVal("mWdata", mWdata, (mdlBusy && mdlOnData) ? dWdata : 32'h0);
            checkVal("iAck",   iAck, eAck && !mdlOnData);
            checkVal("dAck",   dAck, eAck && mdlOnData);
            checkVal("busErr", busErr, mdlBusy && toNow && !mAck);
            checkVal("iRdata", iRdata, (mdlBusy && !mdlOnData && mAck) ? mRdata : 32'h0);
            checkVal("dRdata", dRdata, (mdlBusy && mdlOnData && mAck) ? mRdata : 32'h0);
            checkVal("busyFlag", dbgState != ST_IDLE, mdlBusy);
        end
        if (!reset) begin
            if (iAck || dAck) begin
                if (exp_q.size() == 0) begin
                    checkVal("ack_without_grant", 1, 0);
                end else begin
                    eq = exp_q.pop_front();
                    checkVal("ack_port", dAck, eq);
                end
                grantLog.push_back(dAck);
            end
            if (iAck) begin iDone = 1; lastIRdata = iRdata; end
            if (dAck) begin dDone = 1; capWe = mWe; capMask = mMask; capWdata = mWdata; end
            if (busErr) errCount++;
        end
        if (mReq) begin
            reqCyc++;
            if (mAck) memSeen = 0; else memSeen++;
        end
        // model advance
        if (reset) begin
            mdlBusy = 0; mdlLastData = 1; mdlCnt = 0; exp_q.delete();
        end else if (mdlBusy) begin
            if (mAck || toNow) mdlBusy = 0;
            else mdlCnt++;
        end else if (iReq || dReq) begin
            pickD = (iReq && dReq) ? !mdlLastData : dReq;
            mdlBusy = 1; mdlOnData = pickD; mdlLastData = pickD; mdlCnt = 0;
            exp_q.push_back(pickD);
        end
        stepCount++;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1;
        iPend = 0; dPend = 0; iDrop = 0; dDrop = 0; iDone = 0; dDone = 0;
        driveReq();
        step(0);
        step(0);
        reset = 0;
        memSeen = 0; memNever = 0;
    endtask

    // Run cycles until n completions were logged or the budget runs out.
    task automatic runUntilAcks(input int n, input int budget);
        for (int c = 0; c < budget; c++) begin
            serviceDone();
            driveReq();
            if (grantLog.size() >= n) break;
            step(1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(posedge clk);
        #1;
        doReset();

        // reset state: idle outputs with nothing requested
        driveReq();
        step(1);
        checkVal("reset_mReq", mReq, 0);
        checkVal("reset_dbgState", dbgState, ST_IDLE);

        // single fetch, memory answers at once
        memWaits = 0; memFixedEn = 1; memFixed = 32'h0000_0013;
        grantLog.delete(); reqCyc = 0;
        newFetch(32'h100);
        runUntilAcks(1, 10);
        memFixedEn = 0;
        checkVal("fetch_acks", grantLog.size(), 1);
        checkVal("fetch_irdata", lastIRdata, 32'h0000_0013);
        checkVal("fetch_mreq_cycles", reqCyc, 1);

        // both request after reset: fetch first, then the write
        doReset();
        grantLog.delete(); stepCount = 0;
        newFetch(32'h104);
        newData(32'h200, 1'b1, 4'b0011, 32'h0000_BEEF);
        runUntilAcks(2, 20);
        checkVal("tie_acks", grantLog.size(), 2);
        if (grantLog.size() == 2) begin
            checkVal("tie_first", grantLog[0], 0);
            checkVal("tie_second", grantLog[1], 1);
        end
        checkVal("tie_cycles", stepCount, 4);
        checkVal("tie_mWe", capWe, 1);
        checkVal("tie_mMask", capMask, 4'b0011);
        checkVal("tie_mWdata", capWdata, 32'h0000_BEEF);

        // both held continuously: six alternating grants
        grantLog.delete();
        refillI = 1; refillD = 1;
        newFetch($urandom);
        newData($urandom, 1'b0, 4'hF, $urandom);
        runUntilAcks(6, 40);
        checkVal("alt_acks", grantLog.size(), 6);
        for (int k = 0; k < grantLog.size() && k < 6; k++) begin
            checkVal($sformatf("alt_grant%0d", k), grantLog[k], k % 2);
        end
        refillI = 0; refillD = 0;
        for (int c = 0; c < 20; c++) begin
            serviceDone();
            driveReq();
            if (!iPend && !dPend && !mdlBusy) break;
            step(1);
        end
        checkVal("alt_drained", iPend || dPend, 0);

        // three wait states
        memWaits = 3; grantLog.delete(); reqCyc = 0;
        newFetch(32'h300);
        runUntilAcks(1, 20);
        checkVal("wait3_acks", grantLog.size(), 1);
        checkVal("wait3_mreq_cycles", reqCyc, 4);
        memWaits = 0;

        // memory never answers
        grantLog.delete(); errCount = 0; memNever = 1;
        newData(32'h400, 1'b0, 4'hF, 32'h0);
        for (int c = 0; c < 10; c++) begin
            serviceDone();
            driveReq();
            step(1);
        end
`ifdef BUS_TIMEOUT_EN
        checkVal("stall_buserr_count", errCount, 1);
        checkVal("stall_acks", grantLog.size(), 1);
`else
        checkVal("stall_mreq_held", mReq, 1);
        checkVal("stall_acks", grantLog.size(), 0);
`endif

        // reset in the middle of a data transaction
        doReset();
        memNever = 1;
        newData(32'h500, 1'b1, 4'b1100, 32'h1234);
        for (int c = 0; c < 3; c++) begin
            serviceDone();
            driveReq();
            step(1);
        end
        checkVal("rst_busy_d_before", dbgState, ST_BUSY_D);
        reset = 1;
        step(0);
        reset = 0;
        iPend = 0; dPend = 0; iDone = 0; dDone = 0;
        driveReq();
        memNever = 0; memSeen = 0;
        #1;
        checkVal("rst_mreq_after", mReq, 0);
        checkVal("rst_dack_after", dAck, 0);
        #1;
        grantLog.delete();
        newFetch(32'h600);
        newData(32'h700, 1'b0, 4'hF, 32'h0);
        runUntilAcks(1, 10);
        checkVal("rst_next_acks", grantLog.size(), 1);
        if (grantLog.size() >= 1) checkVal("rst_next_tie_fetch", grantLog[0], 0);
        runUntilAcks(2, 10);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 399) == 0) doReset();
            serviceDone();
            if (!iPend && $urandom_range(0, 2) == 0) newFetch($urandom);
            if (!dPend && $urandom_range(0, 2) == 0)
                newData($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            if (mdlBusy && !mdlOnData && iPend && $urandom_range(0, 7) == 0) iDrop = 1;
            if (mdlBusy && mdlOnData && dPend && $urandom_range(0, 7) == 0) dDrop = 1;
            if (!mReq) memWaits = $urandom_range(0, 3);
            driveReq();
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
